// File: rtl/castle_move_checker_pkg.sv
// Shared constants, types and square helpers for the castling validator.
package castle_move_checker_pkg;

    localparam int NUM_BOARDS = 12;
    localparam int SQ_COUNT   = 64;
    localparam int POS_W      = NUM_BOARDS * SQ_COUNT;

    // Piece-board indices: black pieces first, then white.
    localparam int BP = 0;
    localparam int BN = 1;
    localparam int BB = 2;
    localparam int BR = 3;
    localparam int BQ = 4;
    localparam int BK = 5;
    localparam int WP = 6;
    localparam int WN = 7;
    localparam int WB = 8;
    localparam int WR = 9;
    localparam int WQ = 10;
    localparam int WK = 11;

    typedef enum logic [1:0] {
        SIDE_NONE,
        SIDE_KING,
        SIDE_QUEEN
    } castleSide_t;

    // Square index y*8+x, so bit 0 is a1 and bit 63 is h8.
    function automatic logic [5:0] sq(input logic [2:0] x, input logic [2:0] y);
        return {y, x};
    endfunction

    function automatic logic onBoard(input int x, input int y);
        return (x >= 0) && (x < 8) && (y >= 0) && (y < 8);
    endfunction

endpackage

// File: rtl/castle_move_checker_attack_set_gen.sv
// Combinational map of every square attacked by the side not to move.
module attack_set_gen
    import castle_move_checker_pkg::*;
(
    input  logic [POS_W-1:0]    i_position,
    input  logic                i_color,
    output logic [SQ_COUNT-1:0] o_attack
);

    // Walk every enemy piece and mark its pawn, leaper and sliding-ray targets.
    always_comb begin : attackGen
        logic [SQ_COUNT-1:0] occ;
        logic [SQ_COUNT-1:0] pawns;
        logic [SQ_COUNT-1:0] knights;
        logic [SQ_COUNT-1:0] diagSliders;
        logic [SQ_COUNT-1:0] orthSliders;
        logic [SQ_COUNT-1:0] kings;
        int                  x;
        int                  y;
        int                  nx;
        int                  ny;
        int                  pawnDy;
        logic                blocked;
        logic                isDiag;

        o_attack = '0;
        occ      = '0;
        x        = 0;
        y        = 0;
        nx       = 0;
        ny       = 0;
        blocked  = 1'b0;
        isDiag   = 1'b0;
        for (int k = 0; k < NUM_BOARDS; k++) begin
            occ = occ | i_position[k*SQ_COUNT +: SQ_COUNT];
        end

        if (i_color) begin
            pawns       = i_position[BP*SQ_COUNT +: SQ_COUNT];
            knights     = i_position[BN*SQ_COUNT +: SQ_COUNT];
            diagSliders = i_position[BB*SQ_COUNT +: SQ_COUNT] | i_position[BQ*SQ_COUNT +: SQ_COUNT];
            orthSliders = i_position[BR*SQ_COUNT +: SQ_COUNT] | i_position[BQ*SQ_COUNT +: SQ_COUNT];
            kings       = i_position[BK*SQ_COUNT +: SQ_COUNT];
            pawnDy      = -1;
        end else begin
            pawns       = i_position[WP*SQ_COUNT +: SQ_COUNT];
            knights     = i_position[WN*SQ_COUNT +: SQ_COUNT];
            diagSliders = i_position[WB*SQ_COUNT +: SQ_COUNT] | i_position[WQ*SQ_COUNT +: SQ_COUNT];
            orthSliders = i_position[WR*SQ_COUNT +: SQ_COUNT] | i_position[WQ*SQ_COUNT +: SQ_COUNT];
            kings       = i_position[WK*SQ_COUNT +: SQ_COUNT];
            pawnDy      = 1;
        end

        for (int s = 0; s < SQ_COUNT; s++) begin
            x = s % 8;
            y = s / 8;

            if (pawns[6'(s)]) begin
                for (int dx = -1; dx <= 1; dx += 2) begin
                    nx = x + dx;
                    ny = y + pawnDy;
                    if (onBoard(nx, ny)) o_attack[sq(3'(nx), 3'(ny))] = 1'b1;
                end
            end

            for (int dy = -2; dy <= 2; dy++) begin
                for (int dx = -2; dx <= 2; dx++) begin
                    nx = x + dx;
                    ny = y + dy;
                    if (onBoard(nx, ny)) begin
                        if (knights[6'(s)] && ((dx * dy == 2) || (dx * dy == -2)))
                            o_attack[sq(3'(nx), 3'(ny))] = 1'b1;
                        if (kings[6'(s)] && (dx >= -1) && (dx <= 1) && (dy >= -1) && (dy <= 1) &&
                            !((dx == 0) && (dy == 0)))
                            o_attack[sq(3'(nx), 3'(ny))] = 1'b1;
                    end
                end
            end

            for (int dy = -1; dy <= 1; dy++) begin
                for (int dx = -1; dx <= 1; dx++) begin
                    isDiag = (dx != 0) && (dy != 0);
                    if (!((dx == 0) && (dy == 0)) &&
                        ((isDiag && diagSliders[6'(s)]) || (!isDiag && orthSliders[6'(s)]))) begin
                        blocked = 1'b0;
                        for (int step = 1; step < 8; step++) begin
                            nx = x + dx * step;
                            ny = y + dy * step;
                            if (!blocked && onBoard(nx, ny)) begin
                                o_attack[sq(3'(nx), 3'(ny))] = 1'b1;
                                if (occ[sq(3'(nx), 3'(ny))]) blocked = 1'b1;
                            end else begin
                                blocked = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/castle_move_checker.sv
// Registered castling validator: checks a candidate king move and emits the castled position.
module castle_move_checker
    import castle_move_checker_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [2:0]          from_x,
    input  logic [2:0]          from_y,
    input  logic [2:0]          to_x,
    input  logic [2:0]          to_y,
    input  logic                color,
    input  logic [POS_W-1:0]    position,
    output logic                out_valid,
    output logic                is_valid,
    output logic [POS_W-1:0]    castled,
    output logic [SQ_COUNT-1:0] occupancy,
    output logic [SQ_COUNT-1:0] enemy_attack
);

    logic [SQ_COUNT-1:0] w_occupancy;
    logic [SQ_COUNT-1:0] w_attack;
    logic [SQ_COUNT-1:0] w_kingBB;
    logic [SQ_COUNT-1:0] w_rookBB;
    logic [SQ_COUNT-1:0] w_newKing;
    logic [SQ_COUNT-1:0] w_newRook;
    logic [POS_W-1:0]    w_castled;
    logic [2:0]          w_homeRank;
    logic [2:0]          w_kingTo;
    logic [2:0]          w_rookFrom;
    logic [2:0]          w_rookTo;
    logic                w_legal;
    castleSide_t         w_side;

    logic                r_outValid;
    logic                r_isValid;
    logic [POS_W-1:0]    r_castled;
    logic [SQ_COUNT-1:0] r_occupancy;
    logic [SQ_COUNT-1:0] r_attack;

    attack_set_gen u_attackSetGen (
        .i_position (position),
        .i_color    (color),
        .o_attack   (w_attack)
    );

    // Merge all twelve piece boards into one occupancy map.
    always_comb begin
        w_occupancy = '0;
        for (int k = 0; k < NUM_BOARDS; k++) begin
            w_occupancy = w_occupancy | position[k*SQ_COUNT +: SQ_COUNT];
        end
    end

    // Classify the move, test the castling conditions and build the castled position.
    always_comb begin
        w_homeRank = color ? 3'd0 : 3'd7;
        w_kingBB   = color ? position[WK*SQ_COUNT +: SQ_COUNT] : position[BK*SQ_COUNT +: SQ_COUNT];
        w_rookBB   = color ? position[WR*SQ_COUNT +: SQ_COUNT] : position[BR*SQ_COUNT +: SQ_COUNT];

        w_side = SIDE_NONE;
        if ((from_x == 3'd4) && (from_y == w_homeRank) && (to_y == w_homeRank)) begin
            if (to_x == 3'd6)      w_side = SIDE_KING;
            else if (to_x == 3'd2) w_side = SIDE_QUEEN;
        end

        w_legal    = 1'b0;
        w_kingTo   = 3'd4;
        w_rookFrom = 3'd7;
        w_rookTo   = 3'd7;
        case (w_side)
            SIDE_KING: begin
                w_kingTo   = 3'd6;
                w_rookFrom = 3'd7;
                w_rookTo   = 3'd5;
                w_legal    = w_kingBB[sq(3'd4, w_homeRank)] && w_rookBB[sq(3'd7, w_homeRank)] &&
                             !w_occupancy[sq(3'd5, w_homeRank)] && !w_occupancy[sq(3'd6, w_homeRank)] &&
                             !w_attack[sq(3'd4, w_homeRank)] && !w_attack[sq(3'd5, w_homeRank)] &&
                             !w_attack[sq(3'd6, w_homeRank)];
            end
            SIDE_QUEEN: begin
                w_kingTo   = 3'd2;
                w_rookFrom = 3'd0;
                w_rookTo   = 3'd3;
                w_legal    = w_kingBB[sq(3'd4, w_homeRank)] && w_rookBB[sq(3'd0, w_homeRank)] &&
                             !w_occupancy[sq(3'd1, w_homeRank)] && !w_occupancy[sq(3'd2, w_homeRank)] &&
                             !w_occupancy[sq(3'd3, w_homeRank)] &&
                             !w_attack[sq(3'd2, w_homeRank)] && !w_attack[sq(3'd3, w_homeRank)] &&
                             !w_attack[sq(3'd4, w_homeRank)];
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase

        w_newKing = (w_kingBB & ~(64'd1 << sq(3'd4, w_homeRank))) | (64'd1 << sq(w_kingTo, w_homeRank));
        w_newRook = (w_rookBB & ~(64'd1 << sq(w_rookFrom, w_homeRank))) | (64'd1 << sq(w_rookTo, w_homeRank));

        w_castled = position;
        if (w_legal) begin
            if (color) begin
                w_castled[WK*SQ_COUNT +: SQ_COUNT] = w_newKing;
                w_castled[WR*SQ_COUNT +: SQ_COUNT] = w_newRook;
            end else begin
                w_castled[BK*SQ_COUNT +: SQ_COUNT] = w_newKing;
                w_castled[BR*SQ_COUNT +: SQ_COUNT] = w_newRook;
            end
        end
    end

    // Capture results on accepted requests; the strobe is the request delayed one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid  <= 1'b0;
            r_isValid   <= 1'b0;
            r_castled   <= '0;
            r_occupancy <= '0;
            r_attack    <= '0;
        end else begin
            r_outValid <= in_valid;
            if (in_valid) begin
                r_isValid   <= w_legal;
                r_castled   <= w_castled;
                r_occupancy <= w_occupancy;
                r_attack    <= w_attack;
            end
        end
    end

    assign out_valid    = r_outValid;
    assign is_valid     = r_isValid;
    assign castled      = r_castled;
    assign occupancy    = r_occupancy;
    assign enemy_attack = r_attack;

endmodule

// File: tb/tb_castle_move_checker.sv
// Directed bench for the castling validator with hand-computed expectations.
module tb_castle_move_checker;

    logic         clk;
    logic         rst;
    logic         inValid;
    logic [2:0]   fromX;
    logic [2:0]   fromY;
    logic [2:0]   toX;
    logic [2:0]   toY;
    logic         color;
    logic [767:0] position;
    logic         outValid;
    logic         isValid;
    logic [767:0] castled;
    logic [63:0]  occupancy;
    logic [63:0]  enemyAttack;

    logic [767:0] expPos;
    logic [63:0]  expMask;
    int           checkCount;
    int           errorCount;

    castle_move_checker dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (inValid),
        .from_x       (fromX),
        .from_y       (fromY),
        .to_x         (toX),
        .to_y         (toY),
        .color        (color),
        .position     (position),
        .out_valid    (outValid),
        .is_valid     (isValid),
        .castled      (castled),
        .occupancy    (occupancy),
        .enemy_attack (enemyAttack)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expectation and tally the result.
    task automatic checkOutput(input string tag, input logic [767:0] observed, input logic [767:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Set one piece on a 768-bit position vector.
    function automatic logic [767:0] addPiece(input logic [767:0] pos, input int board, input int square);
        logic [767:0] r;
        r = pos;
        r[board*64 +: 64] = r[board*64 +: 64] | (64'd1 << square);
        return r;
    endfunction

    function automatic logic [63:0] maskOf(input int squares[$]);
        logic [63:0] m;
        m = '0;
        foreach (squares[i]) m = m | (64'd1 << squares[i]);
        return m;
    endfunction

    // Present one request for a single cycle, returning half a cycle after the result edge.
    task automatic applyStimulus(input int fx, input int fy, input int tx, input int ty,
                                 input logic col, input logic [767:0] pos);
        @(negedge clk);
        fromX    = 3'(fx);
        fromY    = 3'(fy);
        toX      = 3'(tx);
        toY      = 3'(ty);
        color    = col;
        position = pos;
        inValid  = 1'b1;
        @(negedge clk);
        inValid  = 1'b0;
    endtask

    initial begin
        logic [767:0] basePos;
        checkCount = 0;
        errorCount = 0;
        rst      = 1'b1;
        inValid  = 1'b0;
        fromX    = '0;
        fromY    = '0;
        toX      = '0;
        toY      = '0;
        color    = 1'b0;
        position = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 768'(outValid), 768'(0));
        checkOutput("reset_is_valid", 768'(isValid), 768'(0));
        checkOutput("reset_castled", castled, 768'(0));
        checkOutput("reset_occupancy", 768'(occupancy), 768'(0));
        checkOutput("reset_attack", 768'(enemyAttack), 768'(0));
        rst = 1'b0;

        // White kingside: WK e1, WR h1, BK e8.
        basePos = '0;
        basePos = addPiece(basePos, 11, 4);
        basePos = addPiece(basePos, 9, 7);
        basePos = addPiece(basePos, 5, 60);
        applyStimulus(4, 0, 6, 0, 1'b1, basePos);
        expPos = '0;
        expPos = addPiece(expPos, 11, 6);
        expPos = addPiece(expPos, 9, 5);
        expPos = addPiece(expPos, 5, 60);
        checkOutput("ks_out_valid", 768'(outValid), 768'(1));
        checkOutput("ks_is_valid", 768'(isValid), 768'(1));
        checkOutput("ks_castled", castled, expPos);
        checkOutput("ks_occupancy", 768'(occupancy), 768'(maskOf('{4, 7, 60})));
        checkOutput("ks_attack", 768'(enemyAttack), 768'(maskOf('{51, 52, 53, 59, 61})));
        @(negedge clk);
        checkOutput("ks_out_valid_drop", 768'(outValid), 768'(0));
        checkOutput("ks_is_valid_hold", 768'(isValid), 768'(1));

        // Same setup with BR f8 attacking f1 down the open file.
        position = addPiece(basePos, 3, 61);
        applyStimulus(4, 0, 6, 0, 1'b1, position);
        checkOutput("ks_attacked_is_valid", 768'(isValid), 768'(0));
        checkOutput("ks_attacked_castled", castled, addPiece(basePos, 3, 61));
        checkOutput("ks_attacked_attack", 768'(enemyAttack),
                    768'(maskOf('{5, 13, 21, 29, 37, 45, 51, 52, 53, 59, 60, 61, 62, 63})));

        // Queenside blocked by WN b1.
        expPos = '0;
        expPos = addPiece(expPos, 11, 4);
        expPos = addPiece(expPos, 9, 0);
        expPos = addPiece(expPos, 5, 60);
        applyStimulus(4, 0, 2, 0, 1'b1, addPiece(expPos, 7, 1));
        checkOutput("qs_blocked_is_valid", 768'(isValid), 768'(0));
        checkOutput("qs_blocked_castled", castled, addPiece(expPos, 7, 1));

        // Queenside with b1 attacked by BR b8 but empty: still legal.
        applyStimulus(4, 0, 2, 0, 1'b1, addPiece(expPos, 3, 57));
        expMask = maskOf('{1, 9, 17, 25, 33, 41, 49, 56, 58, 59, 60, 51, 52, 53, 61});
        expPos = '0;
        expPos = addPiece(expPos, 11, 2);
        expPos = addPiece(expPos, 9, 3);
        expPos = addPiece(expPos, 5, 60);
        expPos = addPiece(expPos, 3, 57);
        checkOutput("qs_b_attacked_is_valid", 768'(isValid), 768'(1));
        checkOutput("qs_b_attacked_castled", castled, expPos);
        checkOutput("qs_b_attacked_attack", 768'(enemyAttack), 768'(expMask));

        // Destination f1 is not a castle square.
        applyStimulus(4, 0, 5, 0, 1'b1, basePos);
        checkOutput("to_x5_is_valid", 768'(isValid), 768'(0));
        checkOutput("to_x5_castled", castled, basePos);

        // Black kingside: BK e8, BR h8, WK e1.
        basePos = '0;
        basePos = addPiece(basePos, 5, 60);
        basePos = addPiece(basePos, 3, 63);
        basePos = addPiece(basePos, 11, 4);
        expPos = '0;
        expPos = addPiece(expPos, 5, 62);
        expPos = addPiece(expPos, 3, 61);
        expPos = addPiece(expPos, 11, 4);
        applyStimulus(4, 7, 6, 7, 1'b0, basePos);
        checkOutput("black_is_valid", 768'(isValid), 768'(1));
        checkOutput("black_castled", castled, expPos);
        checkOutput("black_attack", 768'(enemyAttack), 768'(maskOf('{3, 5, 11, 12, 13})));
        checkOutput("black_occupancy", 768'(occupancy), 768'(maskOf('{4, 60, 63})));

        // Reset lands between a request and its result edge.
        @(negedge clk);
        fromX    = 3'd4;
        fromY    = 3'd7;
        toX      = 3'd6;
        toY      = 3'd7;
        color    = 1'b0;
        position = basePos;
        inValid  = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("mid_reset_out_valid", 768'(outValid), 768'(0));
        checkOutput("mid_reset_is_valid", 768'(isValid), 768'(0));
        checkOutput("mid_reset_castled", castled, 768'(0));
        checkOutput("mid_reset_attack", 768'(enemyAttack), 768'(0));
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_no_pulse", 768'(outValid), 768'(0));

        applyStimulus(4, 7, 6, 7, 1'b0, basePos);
        checkOutput("after_reset_out_valid", 768'(outValid), 768'(1));
        checkOutput("after_reset_is_valid", 768'(isValid), 768'(1));
        checkOutput("after_reset_castled", castled, expPos);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
